bshift_sweep: RTL and testbench
===============================

BSHIFT_SWEEP -- requirements
Module: bshift_sweep

Interface
REQ-001 Parameter HOLD, default 4, sets the dwell cycles per shift amount; legal range 1..255.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 start  in  1  request a sweep; sampled only in IDLE.
REQ-005 a_in  in  8  operand; latched when start is accepted.
REQ-006 mode  in  2  sweep mode, latched with a_in: 00 right only, 01 left only, 10 right then left, 11 treated as 10.
REQ-007 sh_a  out  8  operand driven to the downstream barrel shifter.
REQ-008 sh_amt  out  3  shift amount driven to the shifter.
REQ-009 sh_lr  out  1  direction driven to the shifter: 0 right, 1 left.
REQ-010 sh_y  in  8  combinational result returned by the shifter.
REQ-011 busy  out  1  high while the state is RUN.
REQ-012 step_valid  out  1  one-cycle pulse; y_cap was updated on the preceding edge.
REQ-013 y_cap  out  8  last captured sh_y.
REQ-014 xor_acc  out  8  XOR of all values captured in the current sweep.
REQ-015 done  out  1  one-cycle pulse at sweep completion.

Function
REQ-016 The FSM shall have states IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after the final capture.
- DONE->IDLE unconditionally after one cycle.
REQ-017 On accepting start at edge k:
- latch a_in into sh_a and the mode;
- set sh_amt=0;
- set sh_lr=1 for mode 01, else 0;
- clear xor_acc and the dwell counter;
- busy=1 from edge k.
REQ-018 In RUN, the dwell counter shall count 0..HOLD-1; at the edge where it equals HOLD-1:
- y_cap<=sh_y;
- xor_acc<=xor_acc^sh_y;
- step_valid=1 for the following cycle;
- the counter wraps to 0.
REQ-019 After a capture with sh_amt<7, sh_amt shall increment by 1 on the same edge.
REQ-020 After a capture with sh_amt=7:
- mode 10/11 in the right phase: sh_amt wraps to 0, sh_lr<=1, stay in RUN.
- otherwise: go to DONE.
REQ-021 Captures per sweep shall be N=8 for modes 00/01 and N=16 for modes 10/11; captures occur at edges k+HOLD*n, n=1..N.
REQ-022 done=1 and busy=0 in the single cycle following edge k+HOLD*N; the FSM returns to IDLE on the next edge.
REQ-023 start in RUN or DONE shall be ignored; a_in and mode changes during a sweep shall have no effect.
REQ-024 sh_a, sh_amt and sh_lr shall hold their values in IDLE and DONE; y_cap and xor_acc shall hold until the next accepted start.
REQ-025 sh_amt shall change only on a capture edge, so sh_y is stable for HOLD cycles before each sample.

Reset
REQ-026 With reset_n=0 at a clock edge, the block shall set:
- state=IDLE, dwell counter=0;
- sh_a=0x00, sh_amt=0, sh_lr=0;
- y_cap=0x00, xor_acc=0x00;
- busy=0, step_valid=0, done=0.
REQ-027 Reset asserted mid-sweep shall abort the sweep with no done pulse, and reset shall override start.

Configuration
REQ-028 Macro SWEEP_ABORT_EN:
- Defined: adds input abort (1 bit). abort=1 in RUN returns the FSM to IDLE on the next edge with no done and no capture on that edge; y_cap and xor_acc keep their values.
- Undefined: no abort port exists.

Verification
REQ-029 HOLD=4, mode=00, a_in=0x60, start pulse -> y_cap sequence 60,30,18,0C,06,03,81,C0, one step_valid every 4 cycles, done 32 cycles after start accept, xor_acc=0x00.
REQ-030 HOLD=4, mode=01, a_in=0x01 -> y_cap sequence 01,02,04,08,10,20,40,80, xor_acc=0xFF, sh_lr=1 throughout.
REQ-031 HOLD=1, mode=10, a_in=0x81 -> 16 consecutive step_valid pulses, sh_lr switches 0->1 after the 8th capture, done 16 cycles after accept.
REQ-032 start re-pulsed mid-sweep with a_in=0xAA -> ignored, sh_a stays at the original value; start while done=1 -> ignored.
REQ-033 reset_n=0 for one edge at capture 3 of a mode 00 sweep -> all outputs at reset values next cycle, no done; a subsequent start runs a full sweep.
REQ-034 SWEEP_ABORT_EN defined, abort at capture 5 -> IDLE next cycle, busy=0, no done, y_cap holds the 5th value.

Source files
------------

// File: rtl/bshift_sweep.sv
// Barrel-shifter sweep sequencer. It steps an external shifter through every
// shift amount, holds each amount for HOLD cycles, and captures the result.
// Optional build macro SWEEP_ABORT_EN adds an 'abort' input that cancels a running sweep.
module bshift_sweep #(
   parameter int HOLD = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] a_in,
   input  logic [1:0] mode,
`ifdef SWEEP_ABORT_EN
   input  logic       abort,
`endif
   output logic [7:0] sh_a,
   output logic [2:0] sh_amt,
   output logic       sh_lr,
   input  logic [7:0] sh_y,
   output logic       busy,
   output logic       step_valid,
   output logic [7:0] y_cap,
   output logic [7:0] xor_acc,
   output logic       done
);

   // state | meaning
   // IDLE  | waiting for start; shifter drive and captures hold
   // RUN   | dwelling on each shift amount, capturing sh_y every HOLD cycles
   // DONE  | one-cycle completion pulse, then back to IDLE
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [7:0] LAST = 8'(HOLD - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       dual;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         dual       <= 1'b0;
         sh_a       <= 8'h00;
         sh_amt     <= 3'd0;
         sh_lr      <= 1'b0;
         y_cap      <= 8'h00;
         xor_acc    <= 8'h00;
         busy       <= 1'b0;
         step_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done       <= 1'b0;
               step_valid <= 1'b0;
               if (start) begin
                  state   <= RUN;
                  sh_a    <= a_in;
                  dual    <= mode[1];
                  sh_amt  <= 3'd0;
                  sh_lr   <= (mode == 2'b01);
                  xor_acc <= 8'h00;
                  cnt     <= 8'd0;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               step_valid <= 1'b0;
`ifdef SWEEP_ABORT_EN
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= 8'd0;
               end else
`endif
               if (cnt == LAST) begin
                  cnt        <= 8'd0;
                  y_cap      <= sh_y;
                  xor_acc    <= xor_acc ^ sh_y;
                  step_valid <= 1'b1;
                  if (sh_amt != 3'd7) begin
                     sh_amt <= sh_amt + 3'd1;
                  end else if (dual && !sh_lr) begin
                     // right phase finished in a two-phase sweep: restart leftwards
                     sh_amt <= 3'd0;
                     sh_lr  <= 1'b1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               done       <= 1'b0;
               step_valid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bshift_sweep.sv
// Bench for bshift_sweep: two instances (HOLD=4 and HOLD=1) driving a rotate
// shifter model, checked every cycle against a sweep-index model.
module tb_bshift_sweep;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n[2];
   logic       start[2];
   logic [7:0] a_in[2];
   logic [1:0] mode[2];
   logic [7:0] sh_a[2];
   logic [2:0] sh_amt[2];
   logic       sh_lr[2];
   logic [7:0] sh_y[2];
   logic       busy[2];
   logic       step_valid[2];
   logic [7:0] y_cap[2];
   logic [7:0] xor_acc[2];
   logic       done[2];
`ifdef SWEEP_ABORT_EN
   logic       abort[2];
`endif

   bshift_sweep #(.HOLD(4)) u_h4 (
      .clk(clk), .reset_n(reset_n[0]), .start(start[0]), .a_in(a_in[0]), .mode(mode[0]),
`ifdef SWEEP_ABORT_EN
      .abort(abort[0]),
`endif
      .sh_a(sh_a[0]), .sh_amt(sh_amt[0]), .sh_lr(sh_lr[0]), .sh_y(sh_y[0]),
      .busy(busy[0]), .step_valid(step_valid[0]), .y_cap(y_cap[0]),
      .xor_acc(xor_acc[0]), .done(done[0]));

   bshift_sweep #(.HOLD(1)) u_h1 (
      .clk(clk), .reset_n(reset_n[1]), .start(start[1]), .a_in(a_in[1]), .mode(mode[1]),
`ifdef SWEEP_ABORT_EN
      .abort(abort[1]),
`endif
      .sh_a(sh_a[1]), .sh_amt(sh_amt[1]), .sh_lr(sh_lr[1]), .sh_y(sh_y[1]),
      .busy(busy[1]), .step_valid(step_valid[1]), .y_cap(y_cap[1]),
      .xor_acc(xor_acc[1]), .done(done[1]));

   int compared = 0;
   int mismatched = 0;

   function automatic logic [7:0] rot(input logic [7:0] a, input int amt, input logic left);
      logic [15:0] d;
      d = {a, a};
      if (left) begin
         d = d << amt;
         return d[15:8];
      end
      d = d >> amt;
      return d[7:0];
   endfunction

   always_comb begin
      for (int i = 0; i < 2; i++) sh_y[i] = rot(sh_a[i], int'(sh_amt[i]), sh_lr[i]);
   end

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: position in a sweep is the cycle count since the accept edge
   int         hold_of[2] = '{4, 1};
   bit         mvalid[2]  = '{0, 0};
   int         mj[2];
   bit         mdc[2];
   logic [7:0] ma[2];
   logic [1:0] mm[2];
   int         mn[2];
   logic [7:0] e_a[2], e_y[2], e_x[2];
   logic [2:0] e_amt[2];
   logic       e_lr[2], e_busy[2], e_sv[2], e_done[2];

   function automatic logic left_of(input int i, input int c);
      return (mm[i] == 2'b01) || (mm[i][1] && c > 8);
   endfunction

   task automatic model_step();
      int c;
      logic [7:0] v;
      for (int i = 0; i < 2; i++) begin
         if (!reset_n[i]) begin
            mvalid[i] = 1; mj[i] = -1; mdc[i] = 0;
            e_a[i] = 0; e_amt[i] = 0; e_lr[i] = 0; e_y[i] = 0; e_x[i] = 0;
            e_busy[i] = 0; e_sv[i] = 0; e_done[i] = 0;
         end else if (mj[i] < 0) begin
            e_sv[i] = 0; e_done[i] = 0;
            if (mdc[i]) mdc[i] = 0;
            else if (start[i]) begin
               mj[i] = 0; ma[i] = a_in[i]; mm[i] = mode[i];
               mn[i] = mode[i][1] ? 16 : 8;
               e_a[i] = a_in[i]; e_amt[i] = 0; e_lr[i] = (mode[i] == 2'b01);
               e_x[i] = 0; e_busy[i] = 1;
            end
         end else begin
            e_sv[i] = 0;
            mj[i]++;
`ifdef SWEEP_ABORT_EN
            if (abort[i]) begin
               mj[i] = -1; e_busy[i] = 0;
            end else
`endif
            if (mj[i] % hold_of[i] == 0) begin
               c = mj[i] / hold_of[i];
               v = rot(ma[i], (c - 1) % 8, left_of(i, c));
               e_y[i] = v; e_x[i] ^= v; e_sv[i] = 1;
               if (c == mn[i]) begin
                  mj[i] = -1; mdc[i] = 1; e_busy[i] = 0; e_done[i] = 1;
               end else begin
                  e_amt[i] = 3'(c % 8);
                  e_lr[i]  = left_of(i, c + 1);
               end
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   logic [7:0] ylog[2][$];

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         string p;
         if (!mvalid[i]) continue;
         p = (i == 0) ? "h4" : "h1";
         chk({p, ".sh_a"}, sh_a[i], e_a[i]);
         chk({p, ".sh_amt"}, sh_amt[i], e_amt[i]);
         chk({p, ".sh_lr"}, sh_lr[i], e_lr[i]);
         chk({p, ".busy"}, busy[i], e_busy[i]);
         chk({p, ".step_valid"}, step_valid[i], e_sv[i]);
         chk({p, ".done"}, done[i], e_done[i]);
         chk({p, ".y_cap"}, y_cap[i], e_y[i]);
         chk({p, ".xor_acc"}, xor_acc[i], e_x[i]);
         if (step_valid[i]) ylog[i].push_back(y_cap[i]);
      end
   end

   task automatic run_sweep(input int i, input logic [7:0] a, input logic [1:0] md,
                            input int restart_at, input bit start_on_done, output int lat);
      lat = -1;
      @(negedge clk);
      ylog[i].delete();
      start[i] = 1; a_in[i] = a; mode[i] = md;
      for (int m = 1; m <= 400; m++) begin
         @(negedge clk);
         if (m == 1) start[i] = 0;
         if (m == restart_at) begin start[i] = 1; a_in[i] = 8'hAA; mode[i] = 2'b01; end
         if (m == restart_at + 1) start[i] = 0;
         if (done[i]) begin lat = m - 1; break; end
      end
      if (start_on_done && lat >= 0) begin
         start[i] = 1;
         @(negedge clk);
         start[i] = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp_r[8];
   logic [7:0] exp_l[8];
   int         lat;
   int         n;
   bit         saw;

   initial begin
      exp_r = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81, 8'hC0};
      exp_l = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      for (int i = 0; i < 2; i++) begin
         reset_n[i] = 0; start[i] = 0; a_in[i] = 0; mode[i] = 0;
`ifdef SWEEP_ABORT_EN
         abort[i] = 0;
`endif
      end
      repeat (3) @(negedge clk);
      reset_n[0] = 1; reset_n[1] = 1;
      chk("reset.busy", busy[0], 0);
      chk("reset.y_cap", y_cap[0], 8'h00);

      // right-only sweep with a mid-sweep start that must be ignored
      run_sweep(0, 8'h60, 2'b00, 10, 0, lat);
      chk("r.latency", lat, 32);
      chk("r.count", ylog[0].size(), 8);
      for (int k = 0; k < 8 && k < ylog[0].size(); k++) chk("r.seq", ylog[0][k], exp_r[k]);
      chk("r.xor", xor_acc[0], 8'h00);
      chk("r.sh_a_kept", sh_a[0], 8'h60);

      // left-only sweep with start pulsed during the done cycle
      run_sweep(0, 8'h01, 2'b01, 0, 1, lat);
      chk("l.latency", lat, 32);
      for (int k = 0; k < 8 && k < ylog[0].size(); k++) chk("l.seq", ylog[0][k], exp_l[k]);
      chk("l.xor", xor_acc[0], 8'hFF);
      chk("l.sh_lr", sh_lr[0], 1);
      chk("l.start_in_done_ignored", busy[0], 0);

      // two-phase sweep at HOLD=1
      run_sweep(1, 8'h81, 2'b10, 0, 0, lat);
      chk("rl.latency", lat, 16);
      chk("rl.count", ylog[1].size(), 16);
      chk("rl.sh_lr_end", sh_lr[1], 1);
      if (ylog[1].size() >= 9) begin
         chk("rl.cap8", ylog[1][7], 8'h03);
         chk("rl.cap9", ylog[1][8], 8'h81);
      end

      // reset in the middle of a sweep
      @(negedge clk);
      start[0] = 1; a_in[0] = 8'h3C; mode[0] = 2'b00;
      @(negedge clk);
      start[0] = 0;
      n = 0;
      for (int m = 0; m < 200 && n < 3; m++) begin
         if (step_valid[0]) n++;
         if (n < 3) @(negedge clk);
      end
      reset_n[0] = 0;
      @(negedge clk);
      reset_n[0] = 1;
      chk("rst.busy", busy[0], 0);
      chk("rst.y_cap", y_cap[0], 8'h00);
      chk("rst.xor", xor_acc[0], 8'h00);
      chk("rst.sh_a", sh_a[0], 8'h00);
      saw = 0;
      repeat (40) begin
         @(negedge clk);
         if (done[0]) saw = 1;
      end
      chk("rst.no_done", saw, 0);
      run_sweep(0, 8'h5A, 2'b11, 0, 0, lat);
      chk("rst.full_after", lat, 64);

`ifdef SWEEP_ABORT_EN
      @(negedge clk);
      start[0] = 1; a_in[0] = 8'h60; mode[0] = 2'b00;
      @(negedge clk);
      start[0] = 0;
      n = 0;
      for (int m = 0; m < 200 && n < 5; m++) begin
         if (step_valid[0]) n++;
         if (n < 5) @(negedge clk);
      end
      abort[0] = 1;
      @(negedge clk);
      abort[0] = 0;
      chk("abort.busy", busy[0], 0);
      chk("abort.done", done[0], 0);
      chk("abort.y_cap", y_cap[0], 8'h06);
      repeat (10) @(negedge clk);
`endif

      // randomized traffic on both instances
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            start[i]   = ($urandom_range(0, 7) == 0);
            a_in[i]    = 8'($urandom_range(0, 255));
            mode[i]    = 2'($urandom_range(0, 3));
            reset_n[i] = ($urandom_range(0, 299) != 0);
`ifdef SWEEP_ABORT_EN
            abort[i]   = ($urandom_range(0, 63) == 0);
`endif
         end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         start[i] = 0; reset_n[i] = 1;
`ifdef SWEEP_ABORT_EN
         abort[i] = 0;
`endif
      end
      repeat (80) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
